// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl
// Purpose  : EX-stage issue/stall/write-back sequencer for the multi-cycle FPU.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [19:0] ctrl,
  input  logic [4:0]  rd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic        fpu_start,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic        wb_en,
  output logic        wb_float,
  output logic        wb_int,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_req;
  logic             w_cnt_last;
  logic             w_accept;
  logic             w_capture;

  assign w_req      = valid_in & ctrl[18];
  assign w_cnt_last = (r_cnt == c_cnt_last);

  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    fpu_start   = 1'b0;
    wb_en       = 1'b0;
    timeout_err = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && !flush) begin
          stall    = 1'b1;
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall = 1'b1;
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          fpu_start = 1'b1;
          w_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        // A done arriving with the flush is the killed op finishing, so skip DRAIN.
        if (flush) begin
          w_next = fpu_done ? S_IDLE : S_DRAIN;
        end else if (fpu_done) begin
          w_capture = 1'b1;
          w_next    = S_WB;
        end else if (w_cnt_last) begin
          timeout_err = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_WB: begin
        wb_en  = ~flush;
        w_next = S_IDLE;
      end
      S_DRAIN: begin
        stall = w_req;
        if (fpu_done || w_cnt_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT || r_state == S_DRAIN) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_op   <= '0;
      fpu_a    <= '0;
      fpu_b    <= '0;
      wb_float <= 1'b0;
      wb_int   <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      if (w_accept) begin
        fpu_op   <= {ctrl[19], ctrl[10:8]};
        fpu_a    <= op_a;
        fpu_b    <= op_b;
        wb_float <= ctrl[15];
        wb_int   <= ctrl[4];
        wb_rd    <= rd;
      end
      if (w_capture) begin
        wb_data <= fpu_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Consumer side of the 20-bit decoded control word. Sits in EX next to the ALU.
- For every valid instruction whose control word selects the FPU result path, it issues the operation to the multi-cycle FPU over a start/done handshake and stalls the pipeline.
- It then returns exactly one write-back pulse to the integer or float register file.
- Non-FPU control words pass untouched; this block never stalls them.

Parameters:
- TIMEOUT, 64, maximum cycles in WAIT before the operation is abandoned.
- CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  EX-stage instruction valid.
- ctrl  in  20  decoded control word.
- rd  in  5  destination register index.
- op_a  in  32  operand A as selected by ctrl[16].
- op_b  in  32  operand B as selected by ctrl[17].
- flush  in  1  kill in-flight instruction.
- stall  out  1  hold IF/ID/EX.
- fpu_start  out  1  one-cycle issue strobe.
- fpu_op  out  4  {ctrl[19], ctrl[10:8]}, latched.
- fpu_a  out  32  latched operand A.
- fpu_b  out  32  latched operand B.
- fpu_done  in  1  FPU result valid, one-cycle pulse.
- fpu_result  in  32  FPU result.
- wb_en  out  1  write-back strobe.
- wb_float  out  1  latched ctrl[15]; 1 = float register file.
- wb_int  out  1  latched ctrl[4]; 1 = integer register file.
- wb_rd  out  5  latched rd.
- wb_data  out  32  captured result.
- timeout_err  out  1  one-cycle error pulse.

Behaviour:
- Control word fields:
  - FPU request = valid_in & ctrl[18].
  - Opcode = {ctrl[19], ctrl[10:8]}: 0 FSUB, 1 FADD, 2 FMUL, 3 FDIV, 4 SGNJ, 5 MIN/MAX, 6 FSQRT, 7 CMP, 8 FCVT.W.S, 9 FCVT.S.W.
- Reset (rst_n low, asynchronous): state=IDLE, counter=0.
  - Outputs stall, fpu_start, wb_en, timeout_err are 0.
  - Latched fpu_op, fpu_a, fpu_b, wb_float, wb_int, wb_rd, wb_data are 0.
  - Reset mid-operation discards everything. Any later stray fpu_done is ignored, because done is only sampled in WAIT and DRAIN.
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE:
  - On FPU request with flush=0: latch opcode, operands, rd, ctrl[15], ctrl[4]; next state ISSUE.
  - stall is combinationally high in this acceptance cycle.
  - Without a request, stall=0.
- ISSUE: fpu_start=1 for exactly this cycle; stall=1; counter cleared; next state WAIT.
- WAIT:
  - stall=1; counter increments each cycle.
  - fpu_done=1: wb_data<=fpu_result; next state WB.
  - Otherwise, counter reaching TIMEOUT-1: timeout_err=1 for one cycle; wb_data unchanged; next state IDLE with no write-back.
- WB:
  - wb_en=1 for exactly one cycle; stall=0 so the pipeline advances; next state IDLE.
  - Minimum latency is 4 cycles from acceptance to wb_en (IDLE, ISSUE, WAIT with done, WB).
- DRAIN:
  - The FPU is still busy with a killed operation.
  - stall = valid_in & ctrl[18]; non-FPU instructions flow through.
  - fpu_done or timeout returns the state to IDLE with no wb_en and no timeout_err.
- flush (highest priority over done and timeout):
  - In IDLE: any request in that cycle is not accepted.
  - In ISSUE: fpu_start is suppressed; next state IDLE.
  - In WAIT: next state DRAIN; a fpu_done in the same cycle counts as the drained completion, so next state is IDLE instead.
  - In WB: wb_en is suppressed; next state IDLE.
- fpu_done outside WAIT and DRAIN is ignored.
- Exactly one wb_en is produced per accepted, unflushed, non-timed-out operation.
- wb_float and wb_int are driven as latched and may both be 0; the register file gates its writes on them.

Test Plan:
- FADD: ctrl=20'b01111000000100000000, op_a=32'h3F800000, op_b=32'h40000000; FPU done 3 cycles after start with 32'h40400000 -> fpu_op=4'd1; one fpu_start pulse; wb_en with wb_float=1, wb_int=0, wb_data=32'h40400000; stall high from acceptance through the last WAIT cycle.
- FCVT.W.S: ctrl=20'b11010000000000010000, rd=5'd7 -> fpu_op=4'd8; wb_int=1, wb_float=0, wb_rd=7.
- Non-FPU: RType ctrl=20'b00000000001000010000 with valid_in=1 for 10 cycles -> stall=0, fpu_start=0, wb_en=0 throughout.
- Timeout: issue FDIV, fpu_done never asserted -> timeout_err pulses exactly TIMEOUT cycles after entering WAIT; no wb_en; state back in IDLE and the next FADD is accepted.
- Flush in WAIT: flush 1 cycle after fpu_start, done 5 cycles later -> no wb_en.
  - A new FPU request during DRAIN is stalled until done, then accepted.
  - A non-FPU request during DRAIN is not stalled.
- Reset in WAIT: rst_n low for 1 cycle -> all outputs 0 immediately; a subsequent fpu_done produces no wb_en.
